// File: rtl/counter_4b_pkg.sv
// Shared definitions for the 4-bit multi-mode counter: mode encodings,
// default width and the simulation stop time used by the bench.
package counter_4b_pkg;

  // Default counter width; the counter module may override it.
  localparam int WIDTH_DEF = 4;

  // Simulation stop time (in bench time units) used as a watchdog bound.
  localparam int TIEMPO = 5000;

  // Operating modes selected by MODO.
  typedef enum logic [1:0] {
    MODE_UP3  = 2'b00,
    MODE_DN1  = 2'b01,
    MODE_UP1  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/counter_4b.sv
// Synchronous multi-mode counter (up by 3, down by 1, up by 1, parallel load)
// with registered ripple-carry-out and load-indication pulses. RCO comes from
// the carry/borrow of the WIDTH-bit arithmetic so counters cascade cleanly.
module counter_4b
  import counter_4b_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             LOAD
);

  // Widened sums: the extra MSB is the carry (up) or borrow (down).
  logic [WIDTH:0] up3_w;
  logic [WIDTH:0] up1_w;
  logic [WIDTH:0] dn1_w;

  assign up3_w = {1'b0, Q} + (WIDTH+1)'(3);
  assign up1_w = {1'b0, Q} + (WIDTH+1)'(1);
  assign dn1_w = {1'b0, Q} - (WIDTH+1)'(1);

  logic [WIDTH-1:0] q_nxt;
  logic             rco_nxt;
  logic             load_nxt;
  logic             inputs_known;

  // Unknown mode or load data is treated as a hold so X never reaches state.
  assign inputs_known = !$isunknown({MODO, D});

  // Next-state selection: value, carry/borrow flag and load flag per mode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // one unassigned; that is what keeps synthesis from inferring a latch.
    q_nxt    = Q;
    rco_nxt  = 1'b0;
    load_nxt = 1'b0;
    if (ENABLE && inputs_known) begin
      case (mode_e'(MODO))
        MODE_UP3: begin
          q_nxt   = up3_w[WIDTH-1:0];
          rco_nxt = up3_w[WIDTH];
        end
        MODE_DN1: begin
          q_nxt   = dn1_w[WIDTH-1:0];
          rco_nxt = dn1_w[WIDTH];
        end
        MODE_UP1: begin
          q_nxt   = up1_w[WIDTH-1:0];
          rco_nxt = up1_w[WIDTH];
        end
        MODE_LOAD: begin
          q_nxt    = D;
          load_nxt = 1'b1;
        end
        default: begin
          q_nxt    = Q;
          rco_nxt  = 1'b0;
          load_nxt = 1'b0;
        end
      endcase
    end
  end

  // State register: asynchronous active-high reset clears all outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values; blocking ones would create ordering-dependent races.
    if (RESET) begin
      Q    <= '0;
      RCO  <= 1'b0;
      LOAD <= 1'b0;
    end else begin
      Q    <= q_nxt;
      RCO  <= rco_nxt;
      LOAD <= load_nxt;
    end
  end

endmodule

// File: tb/tb_counter_4b.sv
// Scoreboard bench for counter_4b: the stimulus process pushes the expected
// Q/RCO/LOAD for every edge it drives; the monitor pops and compares after
// each rising clock or reset edge.
module tb_counter_4b;
  import counter_4b_pkg::*;

  logic       CLK;
  logic       RESET;
  logic       ENABLE;
  logic [1:0] MODO;
  logic [3:0] D;
  logic [3:0] Q;
  logic       RCO;
  logic       LOAD;

  typedef struct {
    logic [3:0] q;
    logic       rco;
    logic       load;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  counter_4b #(.WIDTH(4)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .ENABLE (ENABLE),
    .MODO   (MODO),
    .D      (D),
    .Q      (Q),
    .RCO    (RCO),
    .LOAD   (LOAD)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] q, input logic rco, input logic load, input string tag);
    exp_t e;
    e.q    = q;
    e.rco  = rco;
    e.load = load;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Drive one clock's worth of inputs at the falling edge and record what the
  // next rising edge must produce.
  task automatic step(input logic rst, input logic en, input logic [1:0] m,
                      input logic [3:0] d, input logic [3:0] eq,
                      input logic erco, input logic eload, input string tag);
    @(negedge CLK);
    RESET  = rst;
    ENABLE = en;
    MODO   = m;
    D      = d;
    push(eq, erco, eload, tag);
  endtask

  // Raise RESET mid-cycle; the monitor must see zeros before any clock edge.
  task automatic async_reset(input string tag);
    @(negedge CLK);
    #2;
    push(4'd0, 1'b0, 1'b0, tag);
    RESET = 1'b1;
  endtask

  // Monitor: compare the oldest expectation after each clock or reset edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK or posedge RESET);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".q"}, Q, e.q);
        check({e.tag, ".rco"}, {3'b0, RCO}, {3'b0, e.rco});
        check({e.tag, ".load"}, {3'b0, LOAD}, {3'b0, e.load});
      end
    end
  end

  // Watchdog bound on the whole run.
  initial begin
    #(TIEMPO);
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish_before_%0d", TIEMPO);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [3:0] up3_seq [7];
    logic [3:0] dn1_seq [4];
    int drain;

    RESET  = 1'b1;
    ENABLE = 1'b0;
    MODO   = 2'b00;
    D      = 4'd0;

    // Reset held dominates an enabled count.
    step(1'b1, 1'b1, MODE_UP1, 4'd9, 4'd0, 1'b0, 1'b0, "rst_hold0");
    step(1'b1, 1'b1, MODE_LOAD, 4'd9, 4'd0, 1'b0, 1'b0, "rst_hold1");
    step(1'b0, 1'b0, MODE_UP1, 4'd0, 4'd0, 1'b0, 1'b0, "rst_release");

    // Mode 10 from 0 for 17 edges: 1..15, 0 (RCO), 1.
    for (int i = 1; i <= 17; i++)
      step(1'b0, 1'b1, MODE_UP1, 4'd0, 4'(i % 16), (i == 16), 1'b0, $sformatf("up1_%0d", i));

    // Count on to 9, then reset asynchronously mid-cycle.
    for (int i = 2; i <= 9; i++)
      step(1'b0, 1'b1, MODE_UP1, 4'd0, 4'(i), 1'b0, 1'b0, $sformatf("up1_to9_%0d", i));
    async_reset("async_rst");
    step(1'b1, 1'b1, MODE_UP1, 4'd5, 4'd0, 1'b0, 1'b0, "rst_dominates");
    step(1'b0, 1'b1, MODE_UP1, 4'd0, 4'd1, 1'b0, 1'b0, "first_after_rst");

    // Mode 00 from 0: 3, 6, 9, 12, 15, 2 (RCO), 5.
    step(1'b0, 1'b1, MODE_LOAD, 4'd0, 4'd0, 1'b0, 1'b1, "load0");
    up3_seq = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2, 4'd5};
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b1, MODE_UP3, 4'd0, up3_seq[i], (i == 5), 1'b0, $sformatf("up3_%0d", i));

    // Load 14 then up by 3 wraps to 1; load 13 then up by 3 wraps to 0.
    step(1'b0, 1'b1, MODE_LOAD, 4'd14, 4'd14, 1'b0, 1'b1, "load14");
    step(1'b0, 1'b1, MODE_UP3, 4'd0, 4'd1, 1'b1, 1'b0, "up3_14to1");
    step(1'b0, 1'b1, MODE_LOAD, 4'd13, 4'd13, 1'b0, 1'b1, "load13");
    step(1'b0, 1'b1, MODE_UP3, 4'd0, 4'd0, 1'b1, 1'b0, "up3_13to0");

    // Mode 01 from 2: 1, 0, 15 (RCO), 14.
    step(1'b0, 1'b1, MODE_LOAD, 4'd2, 4'd2, 1'b0, 1'b1, "load2");
    dn1_seq = '{4'd1, 4'd0, 4'd15, 4'd14};
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, MODE_DN1, 4'd0, dn1_seq[i], (i == 2), 1'b0, $sformatf("dn1_%0d", i));

    // Mode 11 held: LOAD stays high; then mode 10 counts from the loaded value.
    step(1'b0, 1'b1, MODE_LOAD, 4'hA, 4'd10, 1'b0, 1'b1, "loadA");
    step(1'b0, 1'b1, MODE_LOAD, 4'd5, 4'd5, 1'b0, 1'b1, "load5_held");
    step(1'b0, 1'b1, MODE_UP1, 4'd0, 4'd6, 1'b0, 1'b0, "up1_after_load");

    // ENABLE low at Q=7 in every mode for 3 edges: hold with no pulses.
    step(1'b0, 1'b1, MODE_LOAD, 4'd7, 4'd7, 1'b0, 1'b1, "load7");
    for (int m = 0; m < 4; m++)
      for (int k = 0; k < 3; k++)
        step(1'b0, 1'b0, 2'(m), 4'd3, 4'd7, 1'b0, 1'b0, $sformatf("hold_m%0d_%0d", m, k));
    step(1'b0, 1'b1, MODE_DN1, 4'd0, 4'd6, 1'b0, 1'b0, "reenable_dn1");

    // Wait for the monitor to drain the scoreboard, bounded.
    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(negedge CLK);
      drain++;
    end
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_4b.md
# counter_4b

Synchronous 4-bit multi-mode counter with parallel load, ripple-carry-out (RCO) and load-indication outputs. It is the design under verification for Part A of the counter project, sits between the stimulus generator and the output checker, and is the building block later cascaded into wider counters via RCO.

## Interface

Parameters:
- WIDTH, 4, counter width in bits; D and Q are WIDTH bits wide; all values below assume 4.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  count/load enable; when low the counter holds.
- MODO  in  2  operating mode, see Operation.
- D  in  WIDTH  parallel-load value, used only in mode 11.
- Q  out  WIDTH  registered counter value.
- RCO  out  1  registered ripple-carry-out; one-cycle pulse on wrap-around.
- LOAD  out  1  registered flag; high for the cycle after a parallel load.

## Operation

- RESET high, asynchronous: Q=0, RCO=0, LOAD=0 immediately, regardless of CLK, and held while RESET is high.
- ENABLE low at a rising edge: Q holds; RCO=0, LOAD=0.
- ENABLE high at a rising edge, by MODO:
  - 00: count up by 3, Q <= (Q+3) mod 16; RCO=1 when Q+3 > 15 (e.g. 13->0, 14->1, 15->2), else 0; LOAD=0.
  - 01: count down by 1, Q <= (Q-1) mod 16; RCO=1 when Q=0 (0->15), else 0; LOAD=0.
  - 10: count up by 1, Q <= (Q+1) mod 16; RCO=1 when Q=15 (15->0), else 0; LOAD=0.
  - 11: parallel load, Q <= D; LOAD=1; RCO=0.
- Arithmetic is modulo 2^WIDTH. RCO is computed from the carry or borrow out of the WIDTH-bit add or subtract, never from comparing Q to a constant after the update.
- If MODO or D contains X or Z, Q, RCO and LOAD all take the values for ENABLE low. No X propagates into state.

## Timing

- Latency of one clock: the inputs sampled at edge n determine Q, RCO and LOAD after edge n.
- RCO and LOAD are pulses that stay high exactly one cycle per qualifying edge. Consecutive qualifying edges keep them high continuously (e.g. mode 11 held for k cycles gives LOAD high for k cycles).
- A mode change takes effect at the next edge. There is no pipeline, no handshake, and no state beyond Q, RCO and LOAD.
- Reset mid-count: the outputs go to 0 asynchronously. The first enabled edge after RESET falls counts from 0, so mode 10 gives Q=1.
- RESET dominates ENABLE, MODO and D at all times.

## Structure

- Shared package holds:
  - MODE_UP3=2'b00, MODE_DN1=2'b01, MODE_UP1=2'b10, MODE_LOAD=2'b11;
  - the default WIDTH=4;
  - the simulation stop time TIEMPO used by the bench.
- Single module with no sub-modules:
  - one combinational next-state block producing next Q, carry/borrow and load flag;
  - one asynchronously reset register block.

## Test plan

- Reset: assert RESET mid-count at Q=9 -> Q=0, RCO=0, LOAD=0 without waiting for a clock edge. Release RESET, then mode 10 -> Q=1 after the first edge.
- Mode 10 from 0 for 17 edges -> Q runs 1..15, 0, 1. RCO=1 only on the edge where 15->0.
- Mode 00 from 0 -> 3, 6, 9, 12, 15, 2 (RCO=1 at 15->2), 5. Separately, load 14 then mode 00 -> Q=1, RCO=1.
- Mode 01 from Q=2 -> 1, 0, 15 (RCO=1 at 0->15), 14.
- Mode 11 with D=4'hA -> Q=10, LOAD=1, RCO=0. Hold mode 11 with D=5 -> Q=5, LOAD stays 1. Switch to mode 10 -> Q=6, LOAD=0.
- ENABLE=0 with Q=7 in every mode for 3 edges -> Q stays 7, RCO=0, LOAD=0. Re-enable in mode 01 -> Q=6.
